// File: rtl/layers_sched.sv
// Job sequencer for the layers datapath: gates the image stream, marks MAC window ends,
// counts pooled results to the sink and pulses done when the job completes.
module layers_sched #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int DEPTH_NB    = 16,
  parameter int GROUP_NB    = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int ADDR_LEN    = 8,
  parameter int ADDR_PIX    = 9,
  parameter int ADDR_CTRL   = 10,
  parameter int ADDR_LAYERS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] lyr_image,
  output logic                          lyr_last,
  output logic                          lyr_val,
  input  logic                          lyr_rdy,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] lyr_result,
  input  logic                          lyr_res_val,
  output logic                          lyr_res_rdy,
  output logic [IMG_WIDTH*DEPTH_NB-1:0] dn_data,
  output logic                          dn_last,
  output logic                          dn_val,
  input  logic                          dn_rdy,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_len_stg, r_pix_stg, r_len, r_pix, r_beat_cnt, r_res_cnt;
  logic [7:0]  r_pool_stg;
  logic [23:0] r_win_total, r_win_cnt, w_win_total;
  logic [8:0]  w_pool_p1;
  logic        r_done, w_done_nxt;
  logic        w_ctrl, w_start, w_abort, w_go, w_active;
  logic        w_in_hs, w_res_hs, w_beat_last, w_win_last, w_res_last;
  logic        w_unused_bits;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

  assign w_ctrl      = cfg_valid && (cfg_addr == CFG_AWIDTH'(ADDR_CTRL));
  assign w_start     = w_ctrl && cfg_data[0];
  assign w_abort     = w_ctrl && cfg_data[1];
  assign w_go        = w_start && !w_abort && (r_state == S_IDLE);
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_pool_p1   = {1'b0, r_pool_stg} + 9'd1;
  assign w_win_total = {8'b0, r_pix_stg} * {15'b0, w_pool_p1};
  assign w_beat_last = (r_beat_cnt == r_len - 16'd1);
  assign w_win_last  = (r_win_cnt == r_win_total - 24'd1);
  assign w_res_last  = (r_res_cnt == r_pix - 16'd1);
  assign w_unused_bits = ^cfg_data[CFG_DWIDTH-1:16];

  assign lyr_image = up_data;
  assign dn_data   = lyr_result;
  assign busy      = w_active;
  assign done      = r_done;

  // Staging regs follow the cfg bus; shadow regs are frozen at job start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_stg   <= 16'd1;
      r_pix_stg   <= 16'd0;
      r_pool_stg  <= 8'd0;
      r_len       <= 16'd1;
      r_pix       <= 16'd0;
      r_win_total <= 24'd0;
    end else begin
      if (cfg_valid && cfg_addr == CFG_AWIDTH'(ADDR_LEN))    r_len_stg  <= cfg_data[15:0];
      if (cfg_valid && cfg_addr == CFG_AWIDTH'(ADDR_PIX))    r_pix_stg  <= cfg_data[15:0];
      if (cfg_valid && cfg_addr == CFG_AWIDTH'(ADDR_LAYERS)) r_pool_stg <= cfg_data[15:8];
      if (w_go) begin
        r_len       <= clamp_len(r_len_stg);
        r_pix       <= r_pix_stg;
        r_win_total <= w_win_total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_done_nxt  = 1'b0;
    up_rdy      = 1'b0;
    lyr_val     = 1'b0;
    lyr_last    = 1'b0;
    lyr_res_rdy = 1'b0;
    dn_val      = 1'b0;
    dn_last     = 1'b0;
    w_in_hs     = 1'b0;
    w_res_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (r_pix_stg != 16'd0) w_next = S_RUN;
          else                    w_done_nxt = 1'b1;
        end
      end
      S_RUN: begin
        up_rdy   = lyr_rdy;
        lyr_val  = up_val;
        lyr_last = w_beat_last;
        w_in_hs  = up_val && lyr_rdy;
        if (w_in_hs && w_beat_last && w_win_last) w_next = S_DRAIN;
      end
      S_DRAIN: ;
      default: w_next = S_IDLE;
    endcase
    // Final result completes the job even if it arrives with the last input beat
    if (w_active) begin
      lyr_res_rdy = dn_rdy;
      dn_val      = lyr_res_val;
      dn_last     = w_res_last;
      w_res_hs    = lyr_res_val && dn_rdy;
      if (w_res_hs && w_res_last) begin
        w_next     = S_IDLE;
        w_done_nxt = 1'b1;
      end
    end
    if (w_abort) begin
      w_next     = S_IDLE;
      w_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_next == S_IDLE) begin
      r_beat_cnt <= 16'd0;
      r_win_cnt  <= 24'd0;
      r_res_cnt  <= 16'd0;
    end else begin
      if (w_in_hs) begin
        if (w_beat_last) begin
          r_beat_cnt <= 16'd0;
          r_win_cnt  <= r_win_cnt + 24'd1;
        end else begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end
      if (w_res_hs) r_res_cnt <= r_res_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_layers_sched.sv
// Directed bench for layers_sched with a small layers stand-in that turns
// completed pool groups into pending results.
module tb_layers_sched;
  localparam int UP_W = 4 * 16;
  localparam int DN_W = 16 * 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     cfg_data;
  logic [4:0]      cfg_addr;
  logic            cfg_valid;
  logic [UP_W-1:0] up_data;
  logic            up_val, up_rdy;
  logic [UP_W-1:0] lyr_image;
  logic            lyr_last, lyr_val, lyr_rdy;
  logic [DN_W-1:0] lyr_result;
  logic            lyr_res_val, lyr_res_rdy;
  logic [DN_W-1:0] dn_data;
  logic            dn_last, dn_val, dn_rdy, busy, done;

  int          n_chk = 0, n_pass = 0;
  int          m_beats = 0, m_res = 0, m_done = 0;
  logic [31:0] m_last = 0, m_dnlast = 0;
  logic        mon_clr = 1'b0;
  int          pend = 0, mw = 0, tb_pool = 0;

  layers_sched dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .lyr_image(lyr_image), .lyr_last(lyr_last), .lyr_val(lyr_val), .lyr_rdy(lyr_rdy),
    .lyr_result(lyr_result), .lyr_res_val(lyr_res_val), .lyr_res_rdy(lyr_res_rdy),
    .dn_data(dn_data), .dn_last(dn_last), .dn_val(dn_val), .dn_rdy(dn_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Layers stand-in: one result per (pool_nb+1) completed MAC windows
  assign lyr_res_val = (pend != 0);
  always @(posedge clk) begin
    int inc;
    inc = 0;
    if (rst || mon_clr) begin
      pend <= 0;
      mw   <= 0;
    end else begin
      if (lyr_val && lyr_rdy && lyr_last) begin
        if (mw == tb_pool) begin
          mw  <= 0;
          inc = 1;
        end else begin
          mw <= mw + 1;
        end
      end
      pend <= pend + inc - ((lyr_res_val && lyr_res_rdy) ? 1 : 0);
    end
  end

  // Handshake monitor; last flags recorded as bit positions of 1-based beat/result numbers
  always @(negedge clk) begin
    if (mon_clr) begin
      m_beats = 0; m_res = 0; m_done = 0; m_last = 0; m_dnlast = 0;
    end else begin
      if (lyr_val && lyr_rdy) begin
        m_beats = m_beats + 1;
        if (lyr_last) m_last = m_last | (32'd1 << m_beats);
      end
      if (dn_val && dn_rdy) begin
        m_res = m_res + 1;
        if (dn_last) m_dnlast = m_dnlast | (32'd1 << m_res);
      end
      if (done) m_done = m_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // All tasks below are entered and left 1 time unit after a rising edge
  task automatic cfg_wr(input logic [4:0] addr, input logic [31:0] data);
    cfg_addr  = addr;
    cfg_data  = data;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(input int len, input int pool, input int pix);
    tb_pool = pool;
    cfg_wr(5'd8, 32'(len));
    cfg_wr(5'd4, 32'(pool) << 8);
    cfg_wr(5'd9, 32'(pix));
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("job_end_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_job(input string tag, input int beats, input logic [31:0] lmask,
                           input int res, input logic [31:0] dmask);
    chk({tag, "_beats"}, 32'(m_beats), 32'(beats));
    chk({tag, "_lyr_last"}, m_last, lmask);
    chk({tag, "_results"}, 32'(m_res), 32'(res));
    chk({tag, "_dn_last"}, m_dnlast, dmask);
    chk({tag, "_done_cnt"}, 32'(m_done), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    up_val = 1'b1; lyr_rdy = 1'b1; dn_rdy = 1'b1;
    up_data = 64'h1111_2222_3333_4444;
    lyr_result = {16{16'hA5C3}};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_up_rdy", 32'(up_rdy), 32'd0);
    chk("rst_lyr_val", 32'(lyr_val), 32'd0);
    chk("rst_res_rdy", 32'(lyr_res_rdy), 32'd0);
    chk("rst_dn_val", 32'(dn_val), 32'd0);
    chk("pass_image", lyr_image[31:0], 32'h3333_4444);
    chk("pass_result", dn_data[DN_W-1 -: 32], 32'hA5C3_A5C3);

    // 1: mac_len=3, pool 0, 2 results
    set_cfg(3, 0, 2); clr_mon();
    cfg_wr(5'd10, 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_idle(200);
    check_job("t1", 6, 32'h48, 2, 32'h4);

    // 2: pool 1, mac_len=2, 1 result
    set_cfg(2, 1, 1); clr_mon();
    cfg_wr(5'd10, 32'd1);
    wait_idle(200);
    check_job("t2", 4, 32'h14, 1, 32'h2);

    // 3: random stalls on source, layers and sink
    set_cfg(5, 0, 4); clr_mon();
    cfg_wr(5'd10, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      up_val  = 1'($urandom_range(0, 1));
      lyr_rdy = 1'($urandom_range(0, 1));
      dn_rdy  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    up_val = 1'b1; lyr_rdy = 1'b1; dn_rdy = 1'b1;
    wait_idle(10);
    check_job("t3", 20, 32'h0010_8420, 4, 32'h10);

    // 4: empty job completes immediately
    set_cfg(3, 0, 0); clr_mon();
    cfg_wr(5'd10, 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_up_rdy", 32'(up_rdy), 32'd0);
    @(posedge clk); #1;
    chk("t4_done_low", 32'(done), 32'd0);
    chk("t4_beats", 32'(m_beats), 32'd0);

    // 5: abort during the 7th beat, then a full job
    set_cfg(3, 0, 4); clr_mon();
    dn_rdy = 1'b0;
    cfg_wr(5'd10, 32'd1);
    repeat (6) @(posedge clk);
    #1 cfg_wr(5'd10, 32'd2);
    chk("t5_beats", 32'(m_beats), 32'd7);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_up_rdy", 32'(up_rdy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("t5_no_done", 32'(m_done), 32'd0);
    dn_rdy = 1'b1; clr_mon();
    cfg_wr(5'd10, 32'd1);
    wait_idle(200);
    check_job("t5b", 12, 32'h1248, 4, 32'h10);

    // 6: PIX write and second START while busy
    set_cfg(2, 0, 2); clr_mon();
    cfg_wr(5'd10, 32'd1);
    cfg_wr(5'd9, 32'd3);
    cfg_wr(5'd10, 32'd1);
    wait_idle(200);
    check_job("t6", 4, 32'h14, 2, 32'h4);
    clr_mon();
    cfg_wr(5'd10, 32'd1);
    wait_idle(200);
    check_job("t6b", 6, 32'h54, 3, 32'h8);

    // 7: reset mid-job restores pix_nb=0
    set_cfg(1, 0, 5); clr_mon();
    dn_rdy = 1'b0;
    cfg_wr(5'd10, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);
    dn_rdy = 1'b1; clr_mon();
    cfg_wr(5'd10, 32'd1);
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_busy2", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
